// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide on magnitudes, one step per clock, with registered results.
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;     // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_q;     // multiplicand / divisor magnitude
    logic               sign_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               start, last;
    logic [WIDTH:0]     msum, trial, dsub;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, mprod;
    logic [WIDTH-1:0]   dres;
    logic               mexc, dexc;

    always_comb begin
        mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        start = ctrl_MULT | ctrl_DIV;
        last  = (count_q == CW'(WIDTH - 1));

        msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt = {msum, acc_q[WIDTH-1:1]};
        mprod   = sign_q ? -mul_nxt : mul_nxt;
        mexc    = (mprod[2*WIDTH-1:WIDTH] != {WIDTH{mprod[WIDTH-1]}});

        // A set borrow bit means the trial subtraction went negative: restore.
        trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        dsub  = trial - {1'b0, opb_q};
        if (!dsub[WIDTH])
            div_nxt = {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_nxt = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        dres = sign_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
        // Only MIN / -1 yields a positive quotient with the top bit set.
        dexc = !sign_q && div_nxt[WIDTH-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            acc_q          <= '0;
            opb_q          <= '0;
            sign_q         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    data_resultRDY <= 1'b0;
                    state_q        <= S_IDLE;
                    if (start) begin
                        count_q <= '0;
                        sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        if (ctrl_MULT) begin
                            acc_q   <= {{WIDTH{1'b0}}, mag_b};
                            opb_q   <= mag_a;
                            state_q <= S_MULT;
                            busy    <= 1'b1;
                        end else if (data_operandB == '0) begin
                            state_q        <= S_DONE;
                            data_result    <= '0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, mag_a};
                            opb_q   <= mag_b;
                            state_q <= S_DIV;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    acc_q   <= mul_nxt;
                    count_q <= count_q + CW'(1);
                    if (last) begin
                        state_q        <= S_DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= mprod[WIDTH-1:0];
                        data_exception <= mexc;
                    end
                end
                S_DIV: begin
                    acc_q   <= div_nxt;
                    count_q <= count_q + CW'(1);
                    if (last) begin
                        state_q        <= S_DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= dres;
                        data_exception <= dexc;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
